// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } spi_arb_state_t;

  localparam logic REQ_CNC = 1'b0;  // command/config block
  localparam logic REQ_DSM = 1'b1;  // dump state machine

  localparam logic [7:0] SPI_ABORT_DATA = 8'hFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the "last served" register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;  // tie goes to whoever was not served last
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/spi_arbiter.sv
// Serializes two requesters onto one SPI master with round-robin fairness,
// stable word/select per transaction and a watchdog on SPI_done.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [2:0]  ss0,
  input  logic [2:0]  ss1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  input  logic        SPI_done,
  input  logic [7:0]  EEP_data,
  output logic        wrt_SPI,
  output logic [15:0] SPI_data,
  output logic [2:0]  ss,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clr_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  spi_arb_state_t state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [15:0]    spi_data_q, spi_data_d;
  logic [2:0]     ss_q, ss_d;
  logic           wrt_q, busy_q;
  logic           gnt0_q, gnt1_q, done0_q, done1_q;

  logic arb_winner, arb_valid, abort;

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (last_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    spi_data_d = spi_data_q;
    ss_d       = ss_q;
    abort      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = LAUNCH;
          owner_d    = arb_winner;
          spi_data_d = (arb_winner == REQ_DSM) ? data1 : data0;
          ss_d       = (arb_winner == REQ_DSM) ? ss1 : ss0;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the expiry cycle is honoured as a normal completion.
        if (SPI_done) begin
          rdata_d = EEP_data;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = SPI_ABORT_DATA;
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= REQ_CNC;
      last_q     <= REQ_DSM;
      cnt_q      <= '0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      spi_data_q <= 16'h0000;
      ss_q       <= 3'b000;
      wrt_q      <= 1'b0;
      busy_q     <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      spi_data_q <= spi_data_d;
      ss_q       <= ss_d;
      // Handshake outputs are decoded from the next state so they are registered.
      wrt_q      <= (state_d == LAUNCH);
      busy_q     <= (state_d != IDLE);
      gnt0_q     <= (state_d != IDLE) && (owner_d == REQ_CNC);
      gnt1_q     <= (state_d != IDLE) && (owner_d == REQ_DSM);
      done0_q    <= (state_d == DONE) && (owner_d == REQ_CNC);
      done1_q    <= (state_d == DONE) && (owner_d == REQ_DSM);
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign wrt_SPI     = wrt_q;
  assign SPI_data    = spi_data_q;
  assign ss          = ss_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: two instances (default and 16-cycle watchdog) on shared
// stimulus, checked every cycle against a timestamp-based transaction model.
module tb_spi_arbiter;

  localparam int TMO_B = 16;

  logic clk = 1'b0;
  logic rst, req0, req1, clr_err, SPI_done;
  logic [15:0] data0, data1;
  logic [2:0]  ss0, ss1;
  logic [7:0]  EEP_data;

  logic [1:0]  gnt0_w, gnt1_w, done0_w, done1_w, wrt_w, busy_w, err_w;
  logic [7:0]  rdata_w    [2];
  logic [15:0] spi_data_w [2];
  logic [2:0]  ss_w       [2];

  always #5 clk = ~clk;

  spi_arbiter dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ss0(ss0), .ss1(ss1), .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .done0(done0_w[0]),
    .done1(done1_w[0]), .rdata(rdata_w[0]), .SPI_done(SPI_done), .EEP_data(EEP_data),
    .wrt_SPI(wrt_w[0]), .SPI_data(spi_data_w[0]), .ss(ss_w[0]), .busy(busy_w[0]),
    .timeout_err(err_w[0]), .clr_err(clr_err)
  );

  spi_arbiter #(.TIMEOUT_CYCLES(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ss0(ss0), .ss1(ss1), .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .done0(done0_w[1]),
    .done1(done1_w[1]), .rdata(rdata_w[1]), .SPI_done(SPI_done), .EEP_data(EEP_data),
    .wrt_SPI(wrt_w[1]), .SPI_data(spi_data_w[1]), .ss(ss_w[1]), .busy(busy_w[1]),
    .timeout_err(err_w[1]), .clr_err(clr_err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Transaction model: each transaction is a grant edge g and a completion edge d.
  int   tmo [2];
  int   m_g [2], m_d [2];
  bit   m_act [2], m_res [2], m_own [2], m_last [2], m_err [2];
  logic [15:0] m_data [2];
  logic [2:0]  m_ss [2];
  logic [7:0]  m_rdata [2];

  // Observation records kept by the compare process.
  int strobe_cnt [2], strobe_cyc [2], prev_strobe [2], done_cyc [2], done0_cnt [2];
  bit seen_gnt1 [2], seen_done1 [2];
  bit glog [$];

  // SPI master stand-in.
  bit       resp_en;
  int       resp_delay;
  logic [7:0] resp_byte;

  task automatic check(input string name, input int dut, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, dut, cyc, act, exp);
    end
  endtask

  initial begin : model
    bit set_err;
    tmo[0] = 4096;
    tmo[1] = TMO_B;
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        set_err = 1'b0;
        if (rst) begin
          m_act[i] = 0; m_res[i] = 0; m_own[i] = 0; m_last[i] = 1; m_err[i] = 0;
          m_data[i] = 16'h0000; m_ss[i] = 3'b000; m_rdata[i] = 8'h00;
        end else begin
          if (m_act[i]) begin
            if (!m_res[i]) begin
              if (cyc >= m_g[i] + 2 && SPI_done) begin
                m_res[i] = 1; m_d[i] = cyc; m_rdata[i] = EEP_data;
              end else if (cyc == m_g[i] + tmo[i] + 1) begin
                m_res[i] = 1; m_d[i] = cyc; m_rdata[i] = 8'hFF; set_err = 1'b1;
              end
            end else if (cyc == m_d[i] + 1) begin
              m_act[i] = 0; m_res[i] = 0; m_last[i] = m_own[i];
            end
          end else if (req0 || req1) begin
            m_own[i]  = (req0 && req1) ? ~m_last[i] : req1;
            m_act[i]  = 1;
            m_g[i]    = cyc;
            m_data[i] = m_own[i] ? data1 : data0;
            m_ss[i]   = m_own[i] ? ss1 : ss0;
          end
          if (set_err) m_err[i] = 1;
          else if (clr_err) m_err[i] = 0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 2; i++) begin
          check("gnt0", i, gnt0_w[i], m_act[i] && !m_own[i]);
          check("gnt1", i, gnt1_w[i], m_act[i] && m_own[i]);
          check("done0", i, done0_w[i], m_res[i] && cyc == m_d[i] && !m_own[i]);
          check("done1", i, done1_w[i], m_res[i] && cyc == m_d[i] && m_own[i]);
          check("wrt_SPI", i, wrt_w[i], m_act[i] && cyc == m_g[i]);
          check("SPI_data", i, spi_data_w[i], m_data[i]);
          check("ss", i, ss_w[i], m_ss[i]);
          check("rdata", i, rdata_w[i], m_rdata[i]);
          check("busy", i, busy_w[i], m_act[i]);
          check("timeout_err", i, err_w[i], m_err[i]);
          if (wrt_w[i]) begin
            strobe_cnt[i]++;
            prev_strobe[i] = strobe_cyc[i];
            strobe_cyc[i] = cyc;
            if (i == 0) glog.push_back(gnt1_w[0]);
          end
          if (done0_w[i] || done1_w[i]) done_cyc[i] = cyc;
          if (done0_w[i]) done0_cnt[i]++;
          if (gnt1_w[i]) seen_gnt1[i] = 1;
          if (done1_w[i]) seen_done1[i] = 1;
        end
      end
    end
  end

  initial begin : spi_model
    int cnt;
    bit pending;
    pending = 0; cnt = 0; SPI_done = 1'b0; EEP_data = 8'h00;
    forever begin
      @(negedge clk);
      SPI_done = 1'b0;
      if (rst) begin
        pending = 0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          SPI_done = 1'b1; EEP_data = resp_byte; pending = 0;
        end
      end else if (resp_en && wrt_w[0]) begin
        pending = 1; cnt = resp_delay;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Bounded wait for a gnt (is_done=0) or done (is_done=1) of requester `which`.
  task automatic wait_flag(input string name, input int dut, input bit is_done,
                           input bit which, input int max);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < max && !hit; k++) begin
      @(negedge clk);
      hit = is_done ? (which ? done1_w[dut] : done0_w[dut])
                    : (which ? gnt1_w[dut] : gnt0_w[dut]);
    end
    check(name, dut, hit, 1'b1);
  endtask

  task automatic serve_both(input int max);
    bit d0, d1;
    d0 = 1'b0; d1 = 1'b0;
    for (int k = 0; k < max && !(d0 && d1); k++) begin
      @(negedge clk);
      if (done0_w[0]) begin req0 = 1'b0; d0 = 1'b1; end
      if (done1_w[0]) begin req1 = 1'b0; d1 = 1'b1; end
    end
    check("serve_both", 0, {d0, d1}, 2'b11);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout cyc %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int base;
    rst = 1'b1; req0 = 0; req1 = 0; data0 = '0; data1 = '0; ss0 = '0; ss1 = '0;
    clr_err = 0; resp_en = 1; resp_delay = 20; resp_byte = 8'h3C;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 0, busy_w[0], 1'b0);
    check("rst_gnt0", 0, gnt0_w[0], 1'b0);
    check("rst_spi_data", 0, spi_data_w[0], 16'h0000);
    check("rst_rdata", 0, rdata_w[0], 8'h00);
    rst = 1'b0;
    tick(1);

    // Single request; the 16-cycle instance aborts before the late SPI_done.
    base = strobe_cnt[0];
    req0 = 1; data0 = 16'hA5C3; ss0 = 3'b001;
    wait_flag("single_gnt0", 0, 0, 0, 5);
    req0 = 0;
    wait_flag("single_done0", 0, 1, 0, 40);
    check("single_rdata", 0, rdata_w[0], 8'h3C);
    check("single_spi_data", 0, spi_data_w[0], 16'hA5C3);
    check("single_ss", 0, ss_w[0], 3'b001);
    check("single_strobes", 0, strobe_cnt[0] - base, 1);
    check("single_latency", 0, done_cyc[0] - strobe_cyc[0], 21);
    check("single_no_gnt1", 0, {seen_gnt1[0], seen_done1[0]}, 2'b00);
    check("abort_latency", 1, done_cyc[1] - strobe_cyc[1], 17);
    check("abort_rdata", 1, rdata_w[1], 8'hFF);
    check("abort_err", 1, err_w[1], 1'b1);
    clr_err = 1; tick(1); clr_err = 0;
    check("clr_err", 1, err_w[1], 1'b0);

    // Simultaneous requests right after reset: 0 then 1.
    resp_delay = 3; resp_byte = 8'h81;
    do_reset();
    glog.delete();
    req0 = 1; req1 = 1; data0 = 16'h1111; data1 = 16'h2222; ss0 = 3'b010; ss1 = 3'b100;
    serve_both(60);
    check("tie_count", 0, glog.size(), 2);
    if (glog.size() == 2) begin
      check("tie_first", 0, glog[0], 1'b0);
      check("tie_second", 0, glog[1], 1'b1);
    end
    // Serve 0 alone so the next tie is resolved with last = 0: order 1, 0.
    req0 = 1;
    wait_flag("prep_gnt0", 0, 0, 0, 5);
    req0 = 0;
    wait_flag("prep_done0", 0, 1, 0, 20);
    glog.delete();
    req0 = 1; req1 = 1;
    serve_both(60);
    check("retie_count", 0, glog.size(), 2);
    if (glog.size() == 2) begin
      check("retie_first", 0, glog[0], 1'b1);
      check("retie_second", 0, glog[1], 1'b0);
    end

    // Starvation: both held high, grants alternate with an IDLE gap.
    do_reset();
    glog.delete();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 60 && glog.size() < 4; k++) @(negedge clk);
    check("starve_count", 0, glog.size() >= 4, 1'b1);
    if (glog.size() >= 4) begin
      check("starve_order", 0, {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);
    end
    check("starve_gap", 0, strobe_cyc[0] - prev_strobe[0], 6);
    req0 = 0; req1 = 0;
    tick(8);

    // Timeout with clr_err held: set wins on the abort cycle, clear follows.
    do_reset();
    resp_en = 0; clr_err = 1;
    req1 = 1; data1 = 16'hBEEF; ss1 = 3'b011;
    wait_flag("to_gnt1", 1, 0, 1, 5);
    req1 = 0;
    wait_flag("to_done1", 1, 1, 1, 25);
    check("to_latency", 1, done_cyc[1] - strobe_cyc[1], 17);
    check("to_rdata", 1, rdata_w[1], 8'hFF);
    check("to_err_set_wins", 1, err_w[1], 1'b1);
    check("to_spi_data", 1, spi_data_w[1], 16'hBEEF);
    tick(1);
    check("to_err_cleared", 1, err_w[1], 1'b0);
    check("to_long_still_busy", 0, busy_w[0], 1'b1);
    clr_err = 0;

    // SPI_done on the expiry cycle: normal completion, no error.
    do_reset();
    resp_en = 1; resp_delay = 16; resp_byte = 8'h5A;
    tick(1);
    req0 = 1; data0 = 16'h0C0C;
    wait_flag("exp_gnt0", 1, 0, 0, 5);
    req0 = 0;
    wait_flag("exp_done0", 1, 1, 0, 25);
    check("exp_latency", 1, done_cyc[1] - strobe_cyc[1], 17);
    check("exp_rdata", 1, rdata_w[1], 8'h5A);
    check("exp_no_err", 1, err_w[1], 1'b0);

    // req1 dropped during WAIT still completes with done1.
    resp_delay = 8; resp_byte = 8'h42;
    tick(2);
    req1 = 1; data1 = 16'h0F0F; ss1 = 3'b110;
    wait_flag("drop_gnt1", 0, 0, 1, 5);
    tick(3);
    req1 = 0;
    wait_flag("drop_done1", 0, 1, 1, 20);
    check("drop_rdata", 0, rdata_w[0], 8'h42);

    // Reset during WAIT: reset values next edge and no done afterwards.
    tick(2);
    req0 = 1; data0 = 16'h7777; ss0 = 3'b111;
    wait_flag("rstw_gnt0", 0, 0, 0, 5);
    req0 = 0;
    tick(3);
    base = done0_cnt[0];
    rst = 1;
    tick(1);
    check("rstw_state", 0, {gnt0_w[0], busy_w[0], wrt_w[0]}, 3'b000);
    check("rstw_spi_data", 0, spi_data_w[0], 16'h0000);
    check("rstw_ss", 0, ss_w[0], 3'b000);
    check("rstw_rdata", 0, rdata_w[0], 8'h00);
    tick(1);
    rst = 0;
    tick(12);
    check("rstw_no_done", 0, done0_cnt[0] - base, 0);

    // Word and select stay latched while the requester's inputs move.
    resp_delay = 10; resp_byte = 8'h99;
    req0 = 1; data0 = 16'h1234; ss0 = 3'b101;
    wait_flag("stab_gnt0", 0, 0, 0, 5);
    req0 = 0;
    tick(3);
    data0 = 16'hFFFF; ss0 = 3'b111;
    tick(1);
    check("stab_spi_data", 0, spi_data_w[0], 16'h1234);
    check("stab_ss", 0, ss_w[0], 3'b101);
    wait_flag("stab_done0", 0, 1, 0, 20);
    tick(2);
    check("stab_hold_after", 0, spi_data_w[0], 16'h1234);
    req0 = 1;
    wait_flag("stab_gnt0_2", 0, 0, 0, 5);
    req0 = 0;
    check("stab_new_data", 0, spi_data_w[0], 16'hFFFF);
    check("stab_new_ss", 0, ss_w[0], 3'b111);
    wait_flag("stab_done0_2", 0, 1, 0, 20);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single SPI master peripheral between the two SPI requesters in the digital core: the command/config block (requester 0: pot and EEPROM commands) and the dump state machine (requester 1: gain/offset reads during dump). It serializes the requests with round-robin fairness and a registered req/grant handshake. It holds `SPI_data`/`ss` stable for the whole transaction and returns the received byte to the owner. A watchdog aborts any transaction whose `SPI_done` never arrives. It replaces the plain OR/mux of the two `wrt_SPI` sources.

## Interface
- `TIMEOUT_CYCLES`, default 4096: clocks allowed in WAIT before abort (must be ≥ 2).
- `clk`  in  1  system clock (only clock).
- `rst`  in  1  synchronous reset, active-high.
- `req0`, `req1`  in  1  level request; held until matching `done`.
- `data0`, `data1`  in  16  SPI word of each requester; sampled at grant.
- `ss0`, `ss1`  in  3  slave select of each requester; sampled at grant.
- `gnt0`, `gnt1`  out  1  owner flag; high from LAUNCH through DONE.
- `done0`, `done1`  out  1  1-clock pulse; transaction finished or aborted.
- `rdata`  out  8  last received byte; valid with `done`, held until the next `done`.
- `SPI_done`  in  1  from the SPI master; transaction complete.
- `EEP_data`  in  8  MISO byte from the SPI master.
- `wrt_SPI`  out  1  1-clock start strobe to the SPI master.
- `SPI_data`  out  16  word to the SPI master.
- `ss`  out  3  slave select to the SPI master.
- `busy`  out  1  high in any state except IDLE.
- `timeout_err`  out  1  sticky; set on abort.
- `clr_err`  in  1  clears `timeout_err`.

## Operation
- FSM has four states: IDLE → LAUNCH → WAIT → DONE → IDLE.
- **IDLE**
  - If any `req` is high, select the winner, latch its `data`/`ss` into the output registers, set its `gnt`, and go to LAUNCH.
  - Single requester: it wins.
  - Both requesting: the requester not served last wins.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
- **LAUNCH**
  - `wrt_SPI`=1 for exactly this cycle.
  - Clear the watchdog counter; go to WAIT.
  - `SPI_done` in this cycle is ignored.
- **WAIT**
  - On `SPI_done`: capture `EEP_data` into `rdata`, go to DONE.
  - Otherwise the counter increments. When it equals TIMEOUT_CYCLES−1, set `timeout_err`, load `rdata`=8'hFF, and go to DONE.
  - `SPI_done` and expiry in the same cycle: the done wins; no error.
- **DONE**
  - Pulse `done` for the owner, update `last` to the owner, go to IDLE.
  - `gnt` deasserts on the transition to IDLE.
- `SPI_data`/`ss` hold the latched values from LAUNCH until the next grant. `ss` is never changed mid-transaction.
- A requester dropping `req` after grant does not cancel the transaction; it still receives `done`.
- A `req` still high in IDLE after `done` is treated as a new request; round-robin still alternates.
- `clr_err` and an error set in the same cycle: set wins.
- Reset values: state=IDLE, `last`=1, `wrt_SPI`=0, `SPI_data`=16'h0000, `ss`=3'b000, `gnt*`=0, `done*`=0, `rdata`=8'h00, `busy`=0, `timeout_err`=0, counter=0.
- Reset asserted mid-transaction returns to IDLE next edge with no `done` pulse. The SPI master is reset by the same `rst`.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES); it must not wrap.

## Timing
- All outputs are registered.
- `req` high in IDLE at edge k:
  - `gnt`, `wrt_SPI`, `SPI_data`, `ss` valid after edge k+1.
  - If `SPI_done` is seen at edge n, `done`/`rdata` are valid after edge n+1 and the FSM is back in IDLE after edge n+2.
- Minimum request-to-strobe latency is 1 clock.
- Back-to-back transactions have at least one IDLE cycle between DONE and the next LAUNCH.
- An aborted transaction gives `done` at LAUNCH+TIMEOUT_CYCLES+1.

## Structure
- Package `spi_arb_pkg`:
  - state enum `spi_arb_state_t` {IDLE, LAUNCH, WAIT, DONE}.
  - constants `REQ_CNC`=0, `REQ_DSM`=1.
  - `SPI_ABORT_DATA`=8'hFF.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `winner`, `valid`.
  - Combinational; the `last` register stays in the parent.
- Top `spi_arbiter` holds the FSM, the latch registers and the watchdog counter.

## Test plan
- Single request: `req0`=1, `data0`=16'hA5C3, `ss0`=3'b001; SPI model returns `SPI_done` 20 clocks after strobe with `EEP_data`=8'h3C. Required: one `wrt_SPI` pulse, `SPI_data`=16'hA5C3, `ss`=001, `done0` pulse, `rdata`=8'h3C, `gnt1`/`done1` never high.
- Simultaneous requests: `req0` and `req1` rise on the same edge after reset, each held until its `done`. Required: requester 0 is served first, then requester 1. On a repeated tie, the order alternates 1, 0.
- Starvation: `req0` held permanently high, `req1`=1. Required: grants alternate 0,1,0,1; each `wrt_SPI` is separated by at least one IDLE cycle.
- Timeout: TIMEOUT_CYCLES=16, `SPI_done` never asserted. Required: `done` 17 clocks after the strobe, `rdata`=8'hFF, `timeout_err`=1. `clr_err` clears it. `SPI_done` on the expiry cycle sets no error.
- Mid-transaction disturbances: `req1` dropped during WAIT still yields `done1`. `rst` asserted in WAIT gives IDLE and all reset values next edge, with no `done`.
- Stability: change `data0`/`ss0` during WAIT. Required: `SPI_data`/`ss` unchanged until the next grant.
